wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have a single clock, clk, and reset is synchronous and active-high on port rst.
REQ-002 Ports SHALL be, one per line, as listed in REQ-003 to REQ-013 (name, direction, width, meaning), with clock and reset first.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 W  input  3  writeback control from the MEM/WB stage: W[0]=reg_write, W[1]=mem_to_reg, W[2]=reserved (ignored).
REQ-006 mem_d  input  64  raw load data from the MEM/WB stage.
REQ-007 alu_d  input  64  ALU result from the MEM/WB stage.
REQ-008 rd_n  input  5  destination register number.
REQ-009 ld_f3  input  3  load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 is treated as LD.
REQ-010 rs1_n, rs2_n  input  5 each  read register numbers from decode.
REQ-011 rs1_d, rs2_d  output  64 each  read data (combinational).
REQ-012 wb_d  output  64  selected writeback value (combinational, for EX forwarding).
REQ-013 wb_cnt  output  32  count of committed register writes.

Function
REQ-014 wb_d SHALL equal alu_d when W[1]=0, and extend(mem_d[low bits], ld_f3) when W[1]=1.
REQ-015 Extension SHALL use mem_d[7:0], [15:0] or [31:0]. LB, LH and LW sign-extend to 64 bits; LBU, LHU and LWU zero-extend; LD passes all 64 bits.
REQ-016 The block SHALL hold 32 registers x0..x31 of 64 bits each; x0 SHALL always read 0 and SHALL never be written.
REQ-017 On each rising clk with rst=0, W[0]=1 and rd_n!=0, register[rd_n] SHALL take wb_d. Write latency is one edge.
REQ-018 Reads SHALL be combinational: rsX_d = 0 if rsX_n=0; else wb_d if W[0]=1 and rd_n=rsX_n (write-through bypass); else register[rsX_n].
REQ-019 The bypass in REQ-018 SHALL apply independently to both ports. When rs1_n=rs2_n=rd_n, both outputs SHALL equal wb_d.
REQ-020 wb_cnt SHALL increment by 1 on each edge where a write per REQ-017 occurs. It SHALL wrap from FFFF_FFFF to 0. A write to rd_n=0 SHALL not count.
REQ-021 When W[0]=0, register contents and wb_cnt SHALL be unchanged, whatever the values of mem_d, alu_d and rd_n.
REQ-022 X or garbage on mem_d SHALL not affect any state when W[1]=0 or W[0]=0.

Reset
REQ-023 On a rising clk with rst=1, all 32 registers and wb_cnt SHALL become 0, and no write SHALL occur that cycle.
REQ-024 During rst=1, rs1_d and rs2_d SHALL still follow REQ-018 combinationally; the state seen after the edge is all-zero.
REQ-025 Asserting rst in the middle of a stream of writes SHALL discard the write presented in the reset cycle. The first write after rst deasserts SHALL land normally.

Structure
REQ-026 Shared package constants: XLEN=64, NREG=32, the ld_f3 encodings, and the W bit indices (W_REGWRITE=0, W_MEMTOREG=1).
REQ-027 One sub-module, load_ext, SHALL implement REQ-015 combinationally (inputs mem_d, ld_f3; output 64-bit). The storage, bypass and counter SHALL stay in wb_regfile.
REQ-028 Storage SHALL be a flip-flop array with one write port and two read ports. No memory macro is used.

Verification
REQ-029 Reset, then read all 32 registers -> all 0; wb_cnt=0.
REQ-030 W=3'b001, alu_d=64'h1234, rd_n=5, with rs1_n=5 in the same cycle -> rs1_d=64'h1234 (bypass); next cycle, with W=0 -> rs1_d=64'h1234 from storage; wb_cnt=1.
REQ-031 W=3'b011, mem_d=64'h0000_0000_0000_0080, rd_n=7, swept over ld_f3 -> x7 becomes FFFF_FFFF_FFFF_FF80 for LB, 0000_0000_0000_0080 for LBU, and 64'h80 for LH/LW/LD.
REQ-032 W=3'b011, mem_d=64'hDEAD_BEEF_8000_0000, ld_f3=LW -> FFFF_FFFF_8000_0000; ld_f3=LWU -> 0000_0000_8000_0000.
REQ-033 W=3'b001, rd_n=0, alu_d=64'hFFFF -> x0 still reads 0 on both ports and wb_cnt is unchanged.
REQ-034 Preload wb_cnt near wrap by forcing, or by 2^32 writes in a long test, -> wraps to 0. Separately, rst=1 asserted with W=3'b001, rd_n=3 -> x3=0 after the edge.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Shared constants for the writeback / register-file slice:
//   XLEN, NREG     - datapath width and register count
//   W_REGWRITE/... - bit positions inside the 3-bit writeback control word
//   ld_f3_e        - load funct3 encodings seen by the load extender
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int XLEN       = 64;
  localparam int NREG       = 32;
  localparam int RIDX_W     = 5;
  localparam int CNT_W      = 32;

  localparam int W_REGWRITE = 0;
  localparam int W_MEMTOREG = 1;

  typedef enum logic [2:0] {
    LDF3_LB  = 3'b000,
    LDF3_LH  = 3'b001,
    LDF3_LW  = 3'b010,
    LDF3_LD  = 3'b011,
    LDF3_LBU = 3'b100,
    LDF3_LHU = 3'b101,
    LDF3_LWU = 3'b110,
    LDF3_RSV = 3'b111   // unused encoding, behaves like LD
  } ld_f3_e;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// ---------------------------------------------------------------------------
// load_ext
// Purely combinational load-data extender.
//   mem_d  in  64  raw load data
//   ld_f3  in   3  load funct3 (byte/half/word/double, signed/unsigned)
//   ext_d  out 64  sign- or zero-extended result
// ---------------------------------------------------------------------------
module load_ext
  import wb_regfile_pkg::*;
(
  input  logic [XLEN-1:0] mem_d,
  input  logic [2:0]      ld_f3,
  output logic [XLEN-1:0] ext_d
);

  always_comb begin
    ext_d = mem_d;
    case (ld_f3_e'(ld_f3))
      LDF3_LB:  ext_d = {{(XLEN-8){mem_d[7]}},   mem_d[7:0]};
      LDF3_LH:  ext_d = {{(XLEN-16){mem_d[15]}}, mem_d[15:0]};
      LDF3_LW:  ext_d = {{(XLEN-32){mem_d[31]}}, mem_d[31:0]};
      LDF3_LBU: ext_d = {{(XLEN-8){1'b0}},       mem_d[7:0]};
      LDF3_LHU: ext_d = {{(XLEN-16){1'b0}},      mem_d[15:0]};
      LDF3_LWU: ext_d = {{(XLEN-32){1'b0}},      mem_d[31:0]};
      default:  ext_d = mem_d;   // LD and the spare encoding pass through
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus 32 x 64-bit register file with write-through bypass.
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-high reset (clears registers + counter)
//   W       in   3  [0]=reg_write, [1]=mem_to_reg, [2]=ignored
//   mem_d   in  64  raw load data
//   alu_d   in  64  ALU result
//   rd_n    in   5  destination register
//   ld_f3   in   3  load funct3
//   rs1_n   in   5  read port 1 register number
//   rs2_n   in   5  read port 2 register number
//   rs1_d   out 64  read data 1 (combinational, bypassed)
//   rs2_d   out 64  read data 2 (combinational, bypassed)
//   wb_d    out 64  selected writeback value (for forwarding)
//   wb_cnt  out 32  committed register writes, wraps
// ---------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        W,
  input  logic [XLEN-1:0]   mem_d,
  input  logic [XLEN-1:0]   alu_d,
  input  logic [RIDX_W-1:0] rd_n,
  input  logic [2:0]        ld_f3,
  input  logic [RIDX_W-1:0] rs1_n,
  input  logic [RIDX_W-1:0] rs2_n,
  output logic [XLEN-1:0]   rs1_d,
  output logic [XLEN-1:0]   rs2_d,
  output logic [XLEN-1:0]   wb_d,
  output logic [CNT_W-1:0]  wb_cnt
);

  logic [XLEN-1:0]           w_ext_d;
  logic [XLEN-1:0]           w_wb_d;
  logic                      w_we;
  logic                      w_unused_w2;
  logic [NREG-1:0][XLEN-1:0] w_rf;
  logic [CNT_W-1:0]          r_wb_cnt;

  // W[2] carries no meaning for this stage.
  assign w_unused_w2 = W[2];

  load_ext u_load_ext (
    .mem_d (mem_d),
    .ld_f3 (ld_f3),
    .ext_d (w_ext_d)
  );

  // mem_d only reaches state through this mux, so garbage on it is harmless
  // whenever mem_to_reg is low.
  assign w_wb_d = W[W_MEMTOREG] ? w_ext_d : alu_d;
  assign wb_d   = w_wb_d;

  // Writes to x0 are dropped here, which also keeps them out of the counter.
  assign w_we = W[W_REGWRITE] && (rd_n != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 has no storage at all.
        assign w_rf[gi] = '0;
      end else begin : g_flop
        logic [XLEN-1:0] r_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_q <= '0;
          end else if (w_we && (rd_n == RIDX_W'(gi))) begin
            r_q <= w_wb_d;
          end
        end
        assign w_rf[gi] = r_q;
      end
    end
  endgenerate

  // Read ports: x0 is hard zero, a same-cycle write to the same register is
  // forwarded so decode never sees a stale value. The bypass stays live
  // during reset; only the state behind it is cleared.
  always_comb begin
    rs1_d = '0;
    if (rs1_n != '0) begin
      if (W[W_REGWRITE] && (rd_n == rs1_n)) begin
        rs1_d = w_wb_d;
      end else begin
        rs1_d = w_rf[rs1_n];
      end
    end
  end

  always_comb begin
    rs2_d = '0;
    if (rs2_n != '0) begin
      if (W[W_REGWRITE] && (rd_n == rs2_n)) begin
        rs2_d = w_wb_d;
      end else begin
        rs2_d = w_rf[rs2_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_cnt <= '0;
    end else if (w_we) begin
      r_wb_cnt <= r_wb_cnt + 1'b1;   // natural wrap at 2^32
    end
  end

  assign wb_cnt = r_wb_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Directed stimulus with an architectural model of the register file.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  W;
  logic [63:0] mem_d;
  logic [63:0] alu_d;
  logic [4:0]  rd_n;
  logic [2:0]  ld_f3;
  logic [4:0]  rs1_n;
  logic [4:0]  rs2_n;
  logic [63:0] rs1_d;
  logic [63:0] rs2_d;
  logic [63:0] wb_d;
  logic [31:0] wb_cnt;

  wb_regfile dut (
    .clk    (clk),
    .rst    (rst),
    .W      (W),
    .mem_d  (mem_d),
    .alu_d  (alu_d),
    .rd_n   (rd_n),
    .ld_f3  (ld_f3),
    .rs1_n  (rs1_n),
    .rs2_n  (rs2_n),
    .rs1_d  (rs1_d),
    .rs2_d  (rs2_d),
    .wb_d   (wb_d),
    .wb_cnt (wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- architectural model ----------------
  logic [63:0] m_regs [32];
  int unsigned m_writes = 0;      // committed writes since last reset
  logic [31:0] cnt_bias = '0;     // accounts for the counter preload
  bit          chk_en = 1'b0;

  function automatic logic [63:0] ext_model(input logic [63:0] m, input logic [2:0] f3);
    case (f3)
      3'd0: return 64'($signed(m[7:0]));
      3'd1: return 64'($signed(m[15:0]));
      3'd2: return 64'($signed(m[31:0]));
      3'd4: return 64'(m[7:0]);
      3'd5: return 64'(m[15:0]);
      3'd6: return 64'(m[31:0]);
      default: return m;
    endcase
  endfunction

  function automatic logic [63:0] wb_model();
    return W[1] ? ext_model(mem_d, ld_f3) : alu_d;
  endfunction

  function automatic logic [63:0] read_model(input logic [4:0] n);
    if (n == 0) return 64'h0;
    if (W[0] && rd_n == n) return wb_model();
    return m_regs[n];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 64'h0;
      m_writes <= 0;
      chk_en   <= 1'b1;
    end else if (W[0] && rd_n != 0) begin
      m_regs[rd_n] <= wb_model();
      m_writes     <= m_writes + 1;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One compare per output per cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_wb_d",   wb_d,   wb_model());
      cmp("model_rs1_d",  rs1_d,  read_model(rs1_n));
      cmp("model_rs2_d",  rs2_d,  read_model(rs2_n));
      cmp("model_wb_cnt", {32'h0, wb_cnt}, {32'h0, 32'(m_writes) + cnt_bias});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic [2:0] w, input logic [63:0] md,
                      input logic [63:0] ad, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [4:0] a, input logic [4:0] b);
    @(posedge clk);
    #1;
    rst = r; W = w; mem_d = md; alu_d = ad; rd_n = rd; ld_f3 = f3; rs1_n = a; rs2_n = b;
    $display("[TB] txn rst=%0b W=%03b mem=%h alu=%h rd=%0d f3=%0d rs1=%0d rs2=%0d",
             r, w, md, ad, rd, f3, a, b);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  logic [63:0] lb_exp [8];

  initial begin
    rst = 1'b1; W = 3'b001; mem_d = '0; alu_d = 64'h5555; rd_n = 5'd3;
    ld_f3 = 3'd0; rs1_n = 5'd3; rs2_n = 5'd0;

    // Reset with a write presented: x3 must come out zero.
    step(1'b1, 3'b001, 64'h0, 64'hAAAA_0000_1111_2222, 5'd3, 3'd0, 5'd3, 5'd3);
    settle();
    cmp("rst_bypass_rs1", rs1_d, 64'hAAAA_0000_1111_2222);
    step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd3, 5'd0);
    settle();
    cmp("rst_x3_zero", rs1_d, 64'h0);
    cmp("rst_cnt_zero", {32'h0, wb_cnt}, 64'h0);

    // All registers read zero after reset.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 3'b000, $urandom, $urandom, 5'(i), 3'd0, 5'(i), 5'(i + 16));
      settle();
      cmp("rst_read_rs1", rs1_d, 64'h0);
      cmp("rst_read_rs2", rs2_d, 64'h0);
    end

    // Write x5 with bypass, then read from storage.
    step(1'b0, 3'b001, 64'h0, 64'h1234, 5'd5, 3'd0, 5'd5, 5'd0);
    settle();
    cmp("bypass_x5", rs1_d, 64'h1234);
    step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd5, 5'd0);
    settle();
    cmp("stored_x5", rs1_d, 64'h1234);
    cmp("cnt_after_x5", {32'h0, wb_cnt}, 64'd1);

    // Load-extension sweep on 0x80.
    lb_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
    for (int i = 1; i < 8; i++) lb_exp[i] = 64'h80;
    for (int f = 0; f < 8; f++) begin
      step(1'b0, 3'b011, 64'h80, 64'h0, 5'd7, 3'(f), 5'd0, 5'd7);
      settle();
      cmp("ld80_bypass", rs2_d, lb_exp[f]);
      step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd7, 5'd0);
      settle();
      cmp("ld80_stored", rs1_d, lb_exp[f]);
    end

    // Word sign/zero extension.
    step(1'b0, 3'b011, 64'hDEAD_BEEF_8000_0000, 64'h0, 5'd8, 3'd2, 5'd8, 5'd0);
    settle();
    cmp("lw_sign", rs1_d, 64'hFFFF_FFFF_8000_0000);
    step(1'b0, 3'b011, 64'hDEAD_BEEF_8000_0000, 64'h0, 5'd9, 3'd6, 5'd8, 5'd9);
    settle();
    cmp("lw_kept", rs1_d, 64'hFFFF_FFFF_8000_0000);
    cmp("lwu_zero", rs2_d, 64'h0000_0000_8000_0000);
    step(1'b0, 3'b011, 64'hDEAD_BEEF_8000_8001, 64'h0, 5'd10, 3'd1, 5'd10, 5'd0);
    settle();
    cmp("lh_sign", rs1_d, 64'hFFFF_FFFF_FFFF_8001);
    step(1'b0, 3'b011, 64'hDEAD_BEEF_8000_8001, 64'h0, 5'd10, 3'd3, 5'd10, 5'd0);
    settle();
    cmp("ld_pass", rs1_d, 64'hDEAD_BEEF_8000_8001);

    // Write to x0 is ignored and not counted (count now 1 + 8 + 4 = 13).
    step(1'b0, 3'b001, 64'h0, 64'hFFFF, 5'd0, 3'd0, 5'd0, 5'd0);
    settle();
    cmp("x0_rs1", rs1_d, 64'h0);
    cmp("x0_rs2", rs2_d, 64'h0);
    step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd0, 5'd0);
    settle();
    cmp("x0_cnt", {32'h0, wb_cnt}, 64'd13);

    // No write when reg_write is low, whatever else is presented.
    step(1'b0, 3'b010, 64'hBAD0_BAD0_BAD0_BAD0, 64'hBAD1, 5'd5, 3'd3, 5'd5, 5'd0);
    step(1'b0, 3'b100, 64'hBAD2, 64'hBAD3, 5'd5, 3'd0, 5'd0, 5'd5);
    settle();
    cmp("nowrite_x5", rs2_d, 64'h1234);
    cmp("nowrite_cnt", {32'h0, wb_cnt}, 64'd13);

    // Both ports bypassed together.
    step(1'b0, 3'b001, 64'h0, 64'hCAFE_F00D, 5'd9, 3'd0, 5'd9, 5'd9);
    settle();
    cmp("dual_bypass_rs1", rs1_d, 64'hCAFE_F00D);
    cmp("dual_bypass_rs2", rs2_d, 64'hCAFE_F00D);

    // Mixed stream checked against the model every cycle.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
           5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom));
    end

    // Reset mid-stream drops its own write; the next write lands.
    step(1'b0, 3'b001, 64'h0, 64'h2222, 5'd2, 3'd0, 5'd0, 5'd0);
    step(1'b1, 3'b001, 64'h0, 64'h3333, 5'd3, 3'd0, 5'd0, 5'd0);
    step(1'b0, 3'b001, 64'h0, 64'h4444, 5'd4, 3'd0, 5'd0, 5'd0);
    step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd3, 5'd4);
    settle();
    cmp("midrst_x3", rs1_d, 64'h0);
    cmp("midrst_x4", rs2_d, 64'h4444);
    cmp("midrst_cnt", {32'h0, wb_cnt}, 64'd1);
    step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd2, 5'd0);
    settle();
    cmp("midrst_x2", rs1_d, 64'h0);

    // Counter wrap via preload.
    step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd0, 5'd0);
    #1;
    force dut.r_wb_cnt = 32'hFFFF_FFFE;
    cnt_bias = 32'hFFFF_FFFE - 32'(m_writes);
    #1;
    release dut.r_wb_cnt;
    settle();
    cmp("preload_cnt", {32'h0, wb_cnt}, 64'hFFFF_FFFE);
    step(1'b0, 3'b001, 64'h0, 64'h11, 5'd11, 3'd0, 5'd0, 5'd0);
    step(1'b0, 3'b001, 64'h0, 64'h12, 5'd12, 3'd0, 5'd0, 5'd0);
    settle();
    cmp("cnt_at_max", {32'h0, wb_cnt}, 64'hFFFF_FFFF);
    step(1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 3'd0, 5'd11, 5'd12);
    settle();
    cmp("cnt_wrapped", {32'h0, wb_cnt}, 64'h0);
    cmp("wrap_x12", rs2_d, 64'h12);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
